// File: rtl/shift_reg_univ_pkg.sv
// Shared mode/direction codes and width helper for the universal shift register.
// Imported by the interface, the top and the frame counter.
package shift_reg_univ_pkg;

    typedef enum logic [1:0] {
        SR_HOLD   = 2'b00,
        SR_SHIFT  = 2'b01,
        SR_ROTATE = 2'b10,
        SR_LOAD   = 2'b11
    } sr_mode_e;

    typedef enum logic {
        SR_LEFT  = 1'b0,
        SR_RIGHT = 1'b1
    } sr_dir_e;

    // Counter width large enough to hold the values 0..n
    function automatic int cntWidth(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/shift_reg_univ_if.sv
// Control/data bundle of the universal shift register; master drives controls,
// slave (the register) returns contents, serial lane, shift count and frame pulse.
interface shift_reg_univ_if
    import shift_reg_univ_pkg::*;
#(
    parameter int N = 4,
    parameter int W = 1
);
    localparam int CW = cntWidth(N);

    logic            en;
    logic [1:0]      mode;
    logic            dir;
    logic [W-1:0]    din;
    logic [N*W-1:0]  load;
    logic [N*W-1:0]  q;
    logic [W-1:0]    dout;
    logic [CW-1:0]   cnt;
    logic            frame_done;

    modport master (
        output en, mode, dir, din, load,
        input  q, dout, cnt, frame_done
    );

    modport slave (
        input  en, mode, dir, din, load,
        output q, dout, cnt, frame_done
    );

endinterface

// File: rtl/shift_reg_univ_frame_cnt.sv
// Modulo-N shift counter: counts inc strobes, wraps after N of them and
// emits a one-cycle wrap pulse; clr restarts the frame and suppresses the pulse.
module shift_reg_univ_frame_cnt
    import shift_reg_univ_pkg::*;
#(
    parameter int N  = 4,
    parameter int CW = cntWidth(N)
) (
    input  logic          clk,
    input  logic          res_n,
    input  logic          i_inc,
    input  logic          i_clr,
    output logic [CW-1:0] o_cnt,
    output logic          o_wrap
);

    localparam logic [CW-1:0] LAST = CW'(N - 1);

    logic [CW-1:0] r_cnt;
    logic          r_wrap;

    // clr has priority so a load on the last shift of a frame never pulses
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            r_cnt  <= '0;
            r_wrap <= 1'b0;
        end else if (i_clr) begin
            r_cnt  <= '0;
            r_wrap <= 1'b0;
        end else if (i_inc) begin
            if (r_cnt == LAST) begin
                r_cnt  <= '0;
                r_wrap <= 1'b1;
            end else begin
                r_cnt  <= r_cnt + CW'(1);
                r_wrap <= 1'b0;
            end
        end else begin
            r_wrap <= 1'b0;
        end
    end

    assign o_cnt  = r_cnt;
    assign o_wrap = r_wrap;

endmodule

// File: rtl/shift_reg_univ.sv
// Universal N-stage x W-bit shift register: shift, rotate, parallel load in either
// direction, with a frame counter that pulses after every N shifts.
module shift_reg_univ
    import shift_reg_univ_pkg::*;
#(
    parameter int             N         = 4,
    parameter int             W         = 1,
    parameter logic [N*W-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             res_n,
    shift_reg_univ_if.slave  bus
);

    localparam int CW = cntWidth(N);

    logic [N*W-1:0] r_q;
    logic [N*W-1:0] w_q_next;
    logic [N*W-1:0] w_shl;
    logic [N*W-1:0] w_shr;
    logic [N*W-1:0] w_rotl;
    logic [N*W-1:0] w_rotr;
    logic           w_inc;
    logic           w_clr;
    logic [CW-1:0]  w_cnt;
    logic           w_wrap;

    // A single stage has no neighbours: shift takes din, rotate is a no-op
    generate
        if (N == 1) begin : g_single
            assign w_shl  = bus.din;
            assign w_shr  = bus.din;
            assign w_rotl = r_q;
            assign w_rotr = r_q;
        end else begin : g_multi
            assign w_shl  = {r_q[(N-1)*W-1:0], bus.din};
            assign w_shr  = {bus.din, r_q[N*W-1:W]};
            assign w_rotl = {r_q[(N-1)*W-1:0], r_q[N*W-1 -: W]};
            assign w_rotr = {r_q[W-1:0], r_q[N*W-1:W]};
        end
    endgenerate

    always_comb begin
        w_q_next = r_q;
        w_inc    = 1'b0;
        w_clr    = 1'b0;
        if (bus.en) begin
            case (sr_mode_e'(bus.mode))
                SR_HOLD: begin
                    w_q_next = r_q;
                end
                SR_SHIFT: begin
                    w_q_next = (bus.dir == SR_RIGHT) ? w_shr : w_shl;
                    w_inc    = 1'b1;
                end
                SR_ROTATE: begin
                    w_q_next = (bus.dir == SR_RIGHT) ? w_rotr : w_rotl;
                    w_inc    = 1'b1;
                end
                SR_LOAD: begin
                    w_q_next = bus.load;
                    w_clr    = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            r_q <= RESET_VAL;
        end else begin
            r_q <= w_q_next;
        end
    end

    shift_reg_univ_frame_cnt #(
        .N  (N),
        .CW (CW)
    ) u_sr_frame_cnt (
        .clk    (clk),
        .res_n  (res_n),
        .i_inc  (w_inc),
        .i_clr  (w_clr),
        .o_cnt  (w_cnt),
        .o_wrap (w_wrap)
    );

    // dout is the lane that the next shift in the selected direction pushes out
    assign bus.dout       = (bus.dir == SR_RIGHT) ? r_q[W-1:0] : r_q[N*W-1 -: W];
    assign bus.q          = r_q;
    assign bus.cnt        = w_cnt;
    assign bus.frame_done = w_wrap;

endmodule

// File: tb/tb_shift_reg_univ.sv
// Self-checking bench: directed scenarios plus random traffic on an N=4,W=1 instance
// against a lane-array model, and directed checks on an N=3,W=2 instance.
module tb_shift_reg_univ;
    import shift_reg_univ_pkg::*;

    logic clk = 1'b0;
    logic res_n;
    int   assertions = 0;
    int   failures   = 0;

    int   mStage[4];
    int   mCount;
    logic mFrame;

    always #5 clk = ~clk;

    shift_reg_univ_if #(.N(4), .W(1)) bus  ();
    shift_reg_univ_if #(.N(3), .W(2)) bus2 ();

    shift_reg_univ #(.N(4), .W(1), .RESET_VAL(4'b0000)) dut (
        .clk   (clk),
        .res_n (res_n),
        .bus   (bus)
    );

    shift_reg_univ #(.N(3), .W(2), .RESET_VAL(6'b000000)) dut2 (
        .clk   (clk),
        .res_n (res_n),
        .bus   (bus2)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        assertions++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model: stage k holds one lane; a frame ends every 4th shift/rotate
    function automatic logic [3:0] modelQ();
        logic [3:0] v;
        for (int k = 0; k < 4; k++) v[k] = mStage[k][0];
        return v;
    endfunction

    function automatic logic modelDout(input logic d);
        return d ? mStage[0][0] : mStage[3][0];
    endfunction

    task automatic modelReset();
        for (int k = 0; k < 4; k++) mStage[k] = 0;
        mCount = 0;
        mFrame = 1'b0;
    endtask

    task automatic modelStep(input logic e, input logic [1:0] m, input logic d,
                             input logic di, input logic [3:0] ld);
        int outLane;
        mFrame = 1'b0;
        if (e && m == 2'd3) begin
            for (int k = 0; k < 4; k++) mStage[k] = int'(ld[k]);
            mCount = 0;
        end else if (e && (m == 2'd1 || m == 2'd2)) begin
            if (!d) begin
                outLane = mStage[3];
                for (int k = 3; k > 0; k--) mStage[k] = mStage[k-1];
                mStage[0] = (m == 2'd1) ? int'(di) : outLane;
            end else begin
                outLane = mStage[0];
                for (int k = 0; k < 3; k++) mStage[k] = mStage[k+1];
                mStage[3] = (m == 2'd1) ? int'(di) : outLane;
            end
            mCount = (mCount + 1) % 4;
            mFrame = (mCount == 0);
        end
    endtask

    task automatic checkOutput(input string tag, input logic d);
        chk({tag, "/q"},     8'(bus.q),          8'(modelQ()));
        chk({tag, "/cnt"},   8'(bus.cnt),        8'(mCount));
        chk({tag, "/frame"}, 8'(bus.frame_done), 8'(mFrame));
        chk({tag, "/dout"},  8'(bus.dout),       8'(modelDout(d)));
    endtask

    // Called just after a rising edge: drive, check the serial lane, clock, check
    task automatic applyStimulus(input string tag, input logic e, input logic [1:0] m,
                                 input logic d, input logic di, input logic [3:0] ld);
        bus.en   = e;
        bus.mode = m;
        bus.dir  = d;
        bus.din  = di;
        bus.load = ld;
        #1;
        chk({tag, "/dout_pre"}, 8'(bus.dout), 8'(modelDout(d)));
        @(posedge clk);
        #1;
        modelStep(e, m, d, di, ld);
        checkOutput(tag, d);
    endtask

    task automatic pulseReset(input string tag);
        res_n = 1'b0;
        #1;
        modelReset();
        checkOutput(tag, bus.dir);
        res_n = 1'b1;
    endtask

    initial begin
        logic e, d, di;
        logic [1:0] m;
        logic [3:0] ld;

        res_n     = 1'b0;
        bus.en    = 1'b0;
        bus.mode  = 2'd0;
        bus.dir   = 1'b0;
        bus.din   = 1'b0;
        bus.load  = 4'd0;
        bus2.en   = 1'b0;
        bus2.mode = 2'd0;
        bus2.dir  = 1'b0;
        bus2.din  = 2'd0;
        bus2.load = 6'd0;
        modelReset();
        #2;
        checkOutput("por", 1'b0);
        @(posedge clk);
        #1;
        res_n = 1'b1;

        // Asynchronous reset between edges after loading a nonzero pattern
        applyStimulus("t1_load", 1'b1, 2'd3, 1'b0, 1'b0, 4'b1011);
        pulseReset("t1_reset");
        chk("t1_q_zero", 8'(bus.q), 8'h00);

        // Serialise 1011 stage 0 first
        applyStimulus("t2_load", 1'b1, 2'd3, 1'b1, 1'b0, 4'b1011);
        for (int i = 0; i < 4; i++) applyStimulus("t2_shr", 1'b1, 2'd1, 1'b1, 1'b0, 4'd0);
        chk("t2_q_end", 8'(bus.q), 8'h00);
        chk("t2_frame_end", 8'(bus.frame_done), 8'h01);

        // Deserialise 1,0,0,1 then a second back-to-back frame
        applyStimulus("t3_s0", 1'b1, 2'd1, 1'b0, 1'b1, 4'd0);
        applyStimulus("t3_s1", 1'b1, 2'd1, 1'b0, 1'b0, 4'd0);
        applyStimulus("t3_s2", 1'b1, 2'd1, 1'b0, 1'b0, 4'd0);
        applyStimulus("t3_s3", 1'b1, 2'd1, 1'b0, 1'b1, 4'd0);
        chk("t3_q_1001", 8'(bus.q), 8'h09);
        for (int i = 0; i < 4; i++) applyStimulus("t3_more", 1'b1, 2'd1, 1'b0, 1'($urandom_range(0, 1)), 4'd0);
        chk("t3_frame2", 8'(bus.frame_done), 8'h01);

        // Rotate a single one around, then one step back to the right
        applyStimulus("t4_load", 1'b1, 2'd3, 1'b0, 1'b0, 4'b0001);
        for (int i = 0; i < 4; i++) applyStimulus("t4_rotl", 1'b1, 2'd2, 1'b0, 1'b1, 4'd0);
        chk("t4_q_back", 8'(bus.q), 8'h01);
        applyStimulus("t4_rotr", 1'b1, 2'd2, 1'b1, 1'b0, 4'd0);
        chk("t4_q_1000", 8'(bus.q), 8'h08);

        // Enable gaps stretch the frame; load on the last count suppresses the pulse
        applyStimulus("t5_load", 1'b1, 2'd3, 1'b1, 1'b0, 4'b0110);
        for (int i = 0; i < 2; i++) applyStimulus("t5_shr", 1'b1, 2'd1, 1'b1, 1'b1, 4'd0);
        for (int i = 0; i < 3; i++) applyStimulus("t5_gap", 1'b0, 2'd1, 1'b1, 1'b0, 4'd0);
        chk("t5_cnt_held", 8'(bus.cnt), 8'h02);
        for (int i = 0; i < 2; i++) applyStimulus("t5_resume", 1'b1, 2'd1, 1'b1, 1'b0, 4'd0);
        chk("t5_frame", 8'(bus.frame_done), 8'h01);
        for (int i = 0; i < 3; i++) applyStimulus("t5_pre", 1'b1, 2'd1, 1'b0, 1'b1, 4'd0);
        chk("t5_cnt3", 8'(bus.cnt), 8'h03);
        applyStimulus("t5_load_last", 1'b1, 2'd3, 1'b0, 1'b0, 4'b1100);
        chk("t5_no_frame", 8'(bus.frame_done), 8'h00);

        // Random traffic with occasional mid-frame resets
        for (int i = 0; i < 400; i++) begin
            e  = ($urandom_range(0, 7) != 0);
            m  = 2'($urandom_range(0, 3));
            d  = 1'($urandom_range(0, 1));
            di = 1'($urandom_range(0, 1));
            ld = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 49) == 0) pulseReset("rnd_reset");
            applyStimulus("rnd", e, m, d, di, ld);
        end

        // Wide lanes, three stages
        bus.en    = 1'b0;
        bus2.en   = 1'b1;
        bus2.mode = 2'd3;
        bus2.dir  = 1'b0;
        bus2.load = 6'b11_10_01;
        @(posedge clk);
        #1;
        chk("t6_q_load", 8'(bus2.q), 8'h39);
        bus2.mode = 2'd1;
        bus2.din  = 2'b00;
        #1;
        chk("t6_dout_pre", 8'(bus2.dout), 8'h03);
        @(posedge clk);
        #1;
        chk("t6_q_shl", 8'(bus2.q), 8'h24);
        chk("t6_cnt1", 8'(bus2.cnt), 8'h01);
        res_n = 1'b0;
        #1;
        chk("t6_q_reset", 8'(bus2.q), 8'h00);
        chk("t6_cnt_reset", 8'(bus2.cnt), 8'h00);
        modelReset();
        res_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("t6_frame", 8'(bus2.frame_done), 8'((i == 2) ? 1 : 0));
            chk("t6_cnt", 8'(bus2.cnt), 8'((i + 1) % 3));
        end
        bus2.mode = 2'd0;
        @(posedge clk);
        #1;
        chk("t6_frame_clear", 8'(bus2.frame_done), 8'h00);
        checkOutput("t6_main_idle", bus.dir);

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
